// File: rtl/memory_access_bus.sv
// Memory access stage between execute and writeback: issues one req/ack bus
// transaction per load/store, aligns byte lanes, extracts/extends load data,
// and reports misalignment, bus errors and bus timeouts as one-cycle pulses.
//
// Ports:
//   clk, nrst                     clock (rising edge), synchronous active-low reset
//   i_exec_stall, i_fetch_stall   neighbour stalls; an op is accepted only when both are low
//   o_mem_stall                   high for every cycle spent in BUSY
//   i_op, i_dst_gpr, i_result     opcode, destination register, ALU result / effective address
//   i_mem_data                    store data
//   o_req, o_addr, o_rnw, o_be,   bus request, lane-aligned address, read/not-write,
//   o_wdata                       byte enables and lane-replicated store data
//   i_ack, i_rdata, i_err         bus completion, read data and error (valid with i_ack)
//   o_dst_gpr, o_dst_gpr_v        writeback register (0 = none) and value
//   o_exc_align, o_exc_bus,       misalignment / bus-error pulses and faulting address
//   o_exc_addr
module memory_access_bus #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned REGNO_WIDTH = 5,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     i_exec_stall,
   input  logic                     i_fetch_stall,
   output logic                     o_mem_stall,
   input  logic [5:0]               i_op,
   input  logic [REGNO_WIDTH-1:0]   i_dst_gpr,
   input  logic [DATA_WIDTH-1:0]    i_result,
   input  logic [DATA_WIDTH-1:0]    i_mem_data,
   output logic                     o_req,
   output logic [ADDR_WIDTH-1:0]    o_addr,
   output logic                     o_rnw,
   output logic [DATA_WIDTH/8-1:0]  o_be,
   output logic [DATA_WIDTH-1:0]    o_wdata,
   input  logic                     i_ack,
   input  logic [DATA_WIDTH-1:0]    i_rdata,
   input  logic                     i_err,
   output logic [REGNO_WIDTH-1:0]   o_dst_gpr,
   output logic [DATA_WIDTH-1:0]    o_dst_gpr_v,
   output logic                     o_exc_align,
   output logic                     o_exc_bus,
   output logic [ADDR_WIDTH-1:0]    o_exc_addr
);

   localparam int unsigned BEW  = DATA_WIDTH / 8;
   localparam int unsigned OFFW = $clog2(BEW);
   localparam int unsigned HREP = BEW / 2;
   localparam int unsigned WREP = BEW / 4;
   localparam int unsigned TCW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BEW - 1);

   // Memory opcodes; everything else is a pass-through ALU op.
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                  state_q, state_d;
   logic [TCW-1:0]          cnt_q, cnt_d;
   logic                    req_d, rnw_d, exc_align_d, exc_bus_d;
   logic [ADDR_WIDTH-1:0]   addr_d, exc_addr_d;
   logic [BEW-1:0]          be_d;
   logic [DATA_WIDTH-1:0]   wdata_d, v_d;
   logic [REGNO_WIDTH-1:0]  dst_d;

   // Transaction context kept for the completion cycle
   logic [REGNO_WIDTH-1:0]  ld_dst_q, ld_dst_d;
   logic [1:0]              sz_q, sz_d;
   logic                    sgn_q, sgn_d;
   logic [OFFW-1:0]         off_q, off_d;
   logic [ADDR_WIDTH-1:0]   ea_q, ea_d;

   logic                    mem_op, ld_op, sgn_op, misalign;
   logic [1:0]              sz_op;
   logic [ADDR_WIDTH-1:0]   ea_in;
   logic [OFFW-1:0]         off_in;
   logic [DATA_WIDTH-1:0]   lane, ld_val;

   assign ea_in       = i_result[ADDR_WIDTH-1:0];
   assign off_in      = ea_in[OFFW-1:0];
   assign o_mem_stall = (state_q == BUSY);
   assign lane        = i_rdata >> {off_q, 3'b000};

   // Opcode decode
   always_comb begin
      mem_op = 1'b0;
      ld_op  = 1'b0;
      sgn_op = 1'b0;
      sz_op  = SZ_W;
      case (i_op)
         OP_LB:   begin mem_op = 1'b1; ld_op = 1'b1; sgn_op = 1'b1; sz_op = SZ_B; end
         OP_LH:   begin mem_op = 1'b1; ld_op = 1'b1; sgn_op = 1'b1; sz_op = SZ_H; end
         OP_LW:   begin mem_op = 1'b1; ld_op = 1'b1; sgn_op = 1'b1; sz_op = SZ_W; end
         OP_LBU:  begin mem_op = 1'b1; ld_op = 1'b1; sz_op = SZ_B; end
         OP_LHU:  begin mem_op = 1'b1; ld_op = 1'b1; sz_op = SZ_H; end
         OP_SB:   begin mem_op = 1'b1; sz_op = SZ_B; end
         OP_SH:   begin mem_op = 1'b1; sz_op = SZ_H; end
         OP_SW:   begin mem_op = 1'b1; sz_op = SZ_W; end
         default: ;
      endcase
      misalign = ((sz_op == SZ_H) && off_in[0]) ||
                 ((sz_op == SZ_W) && (off_in[1:0] != 2'b00));
   end

   // Load lane extraction with sign/zero extension
   always_comb begin
      case (sz_q)
         SZ_B:    ld_val = sgn_q ? DATA_WIDTH'($signed(lane[7:0]))  : DATA_WIDTH'(lane[7:0]);
         SZ_H:    ld_val = sgn_q ? DATA_WIDTH'($signed(lane[15:0])) : DATA_WIDTH'(lane[15:0]);
         default: ld_val = sgn_q ? DATA_WIDTH'($signed(lane[31:0])) : DATA_WIDTH'(lane[31:0]);
      endcase
   end

   // Next state and next registered outputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = o_req;
      addr_d      = o_addr;
      rnw_d       = o_rnw;
      be_d        = o_be;
      wdata_d     = o_wdata;
      dst_d       = o_dst_gpr;
      v_d         = o_dst_gpr_v;
      exc_align_d = 1'b0;
      exc_bus_d   = 1'b0;
      exc_addr_d  = '0;
      ld_dst_d    = ld_dst_q;
      sz_d        = sz_q;
      sgn_d       = sgn_q;
      off_d       = off_q;
      ea_d        = ea_q;

      case (state_q)
         IDLE: begin
            if (!i_exec_stall && !i_fetch_stall) begin
               if (!mem_op) begin
                  dst_d = i_dst_gpr;
                  v_d   = i_result;
               end else if (misalign) begin
                  exc_align_d = 1'b1;
                  exc_addr_d  = ea_in;
                  dst_d       = '0;
               end else begin
                  state_d  = BUSY;
                  cnt_d    = '0;
                  req_d    = 1'b1;
                  addr_d   = ea_in & ALIGN_MASK;
                  rnw_d    = ld_op;
                  dst_d    = '0;
                  ld_dst_d = i_dst_gpr;
                  sz_d     = sz_op;
                  sgn_d    = sgn_op;
                  off_d    = off_in;
                  ea_d     = ea_in;
                  case (sz_op)
                     SZ_B: begin
                        be_d    = BEW'(1) << off_in;
                        wdata_d = {BEW{i_mem_data[7:0]}};
                     end
                     SZ_H: begin
                        be_d    = BEW'(3) << off_in;
                        wdata_d = {HREP{i_mem_data[15:0]}};
                     end
                     default: begin
                        be_d    = BEW'(15) << off_in;
                        wdata_d = {WREP{i_mem_data[31:0]}};
                     end
                  endcase
               end
            end
         end
         BUSY: begin
            if (i_ack) begin
               state_d = IDLE;
               req_d   = 1'b0;
               if (i_err) begin
                  exc_bus_d  = 1'b1;
                  exc_addr_d = ea_q;
                  dst_d      = '0;
               end else if (o_rnw) begin
                  dst_d = ld_dst_q;
                  v_d   = ld_val;
               end
            end else if ((TIMEOUT != 0) && (cnt_q == TCW'(TIMEOUT - 1))) begin
               // Ack never arrived: report exactly like a bus error
               state_d    = IDLE;
               req_d      = 1'b0;
               exc_bus_d  = 1'b1;
               exc_addr_d = ea_q;
               dst_d      = '0;
            end else begin
               cnt_d = cnt_q + TCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         o_req       <= 1'b0;
         o_addr      <= '0;
         o_rnw       <= 1'b0;
         o_be        <= '0;
         o_wdata     <= '0;
         o_dst_gpr   <= '0;
         o_dst_gpr_v <= '0;
         o_exc_align <= 1'b0;
         o_exc_bus   <= 1'b0;
         o_exc_addr  <= '0;
         ld_dst_q    <= '0;
         sz_q        <= SZ_B;
         sgn_q       <= 1'b0;
         off_q       <= '0;
         ea_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         o_req       <= req_d;
         o_addr      <= addr_d;
         o_rnw       <= rnw_d;
         o_be        <= be_d;
         o_wdata     <= wdata_d;
         o_dst_gpr   <= dst_d;
         o_dst_gpr_v <= v_d;
         o_exc_align <= exc_align_d;
         o_exc_bus   <= exc_bus_d;
         o_exc_addr  <= exc_addr_d;
         ld_dst_q    <= ld_dst_d;
         sz_q        <= sz_d;
         sgn_q       <= sgn_d;
         off_q       <= off_d;
         ea_q        <= ea_d;
      end
   end

endmodule

// File: tb/tb_memory_access_bus.sv
// Bench for memory_access_bus: a 32-bit instance (TIMEOUT=8) and a 64-bit
// instance (TIMEOUT=4) share one stimulus stream; expectations come from a
// byte-level reference model of loads, stores and bus timing.
module tb_memory_access_bus;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   logic        clk = 1'b0;
   logic        nrst, exec_stall, fetch_stall, ack, err;
   logic [5:0]  op;
   logic [4:0]  dst;
   logic [63:0] res, mdata, rdata;

   logic        a_stall, a_req, a_rnw, a_ea, a_eb;
   logic [31:0] a_addr, a_wdata, a_v, a_exc_addr;
   logic [3:0]  a_be;
   logic [4:0]  a_dst;
   logic        b_stall, b_req, b_rnw, b_ea, b_eb;
   logic [31:0] b_addr, b_exc_addr;
   logic [63:0] b_wdata, b_v;
   logic [7:0]  b_be;
   logic [4:0]  b_dst;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   memory_access_bus #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REGNO_WIDTH(5), .TIMEOUT(8)) dut_a (
      .clk(clk), .nrst(nrst), .i_exec_stall(exec_stall), .i_fetch_stall(fetch_stall),
      .o_mem_stall(a_stall), .i_op(op), .i_dst_gpr(dst), .i_result(res[31:0]),
      .i_mem_data(mdata[31:0]), .o_req(a_req), .o_addr(a_addr), .o_rnw(a_rnw), .o_be(a_be),
      .o_wdata(a_wdata), .i_ack(ack), .i_rdata(rdata[31:0]), .i_err(err), .o_dst_gpr(a_dst),
      .o_dst_gpr_v(a_v), .o_exc_align(a_ea), .o_exc_bus(a_eb), .o_exc_addr(a_exc_addr));

   memory_access_bus #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .REGNO_WIDTH(5), .TIMEOUT(4)) dut_b (
      .clk(clk), .nrst(nrst), .i_exec_stall(exec_stall), .i_fetch_stall(fetch_stall),
      .o_mem_stall(b_stall), .i_op(op), .i_dst_gpr(dst), .i_result(res),
      .i_mem_data(mdata), .o_req(b_req), .o_addr(b_addr), .o_rnw(b_rnw), .o_be(b_be),
      .o_wdata(b_wdata), .i_ack(ack), .i_rdata(rdata), .i_err(err), .o_dst_gpr(b_dst),
      .o_dst_gpr_v(b_v), .o_exc_align(b_ea), .o_exc_bus(b_eb), .o_exc_addr(b_exc_addr));

   // Observed outputs indexed by instance (0 = 32-bit, 1 = 64-bit)
   logic        obs_req[2], obs_stall[2], obs_rnw[2], obs_ea[2], obs_eb[2];
   logic [31:0] obs_addr[2], obs_exc_addr[2];
   logic [7:0]  obs_be[2];
   logic [63:0] obs_wdata[2], obs_v[2];
   logic [4:0]  obs_dst[2];

   assign obs_req[0] = a_req;             assign obs_req[1] = b_req;
   assign obs_stall[0] = a_stall;         assign obs_stall[1] = b_stall;
   assign obs_rnw[0] = a_rnw;             assign obs_rnw[1] = b_rnw;
   assign obs_ea[0] = a_ea;               assign obs_ea[1] = b_ea;
   assign obs_eb[0] = a_eb;               assign obs_eb[1] = b_eb;
   assign obs_addr[0] = a_addr;           assign obs_addr[1] = b_addr;
   assign obs_exc_addr[0] = a_exc_addr;   assign obs_exc_addr[1] = b_exc_addr;
   assign obs_be[0] = 8'(a_be);           assign obs_be[1] = b_be;
   assign obs_wdata[0] = 64'(a_wdata);    assign obs_wdata[1] = b_wdata;
   assign obs_v[0] = 64'(a_v);            assign obs_v[1] = b_v;
   assign obs_dst[0] = a_dst;             assign obs_dst[1] = b_dst;

   // ---------------- reference model ----------------
   function automatic int dw_of(input int d);
      return (d == 0) ? 32 : 64;
   endfunction

   function automatic int to_of(input int d);
      return (d == 0) ? 8 : 4;
   endfunction

   function automatic logic [63:0] dmask(input int d);
      return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic int sz_of(input logic [5:0] o);
      if (o == OP_LB || o == OP_LBU || o == OP_SB) return 1;
      if (o == OP_LH || o == OP_LHU || o == OP_SH) return 2;
      return 4;
   endfunction

   function automatic bit is_ld(input logic [5:0] o);
      return (o == OP_LB || o == OP_LH || o == OP_LW || o == OP_LBU || o == OP_LHU);
   endfunction

   function automatic bit is_sgn(input logic [5:0] o);
      return (o == OP_LB || o == OP_LH || o == OP_LW);
   endfunction

   function automatic int off_of(input logic [31:0] a, input int dw);
      return int'(a % 32'(dw / 8));
   endfunction

   function automatic logic [31:0] m_addr(input logic [31:0] a, input int dw);
      return a - 32'(off_of(a, dw));
   endfunction

   function automatic logic [63:0] m_be(input logic [5:0] o, input logic [31:0] a, input int dw);
      logic [63:0] r = 64'd0;
      for (int i = 0; i < sz_of(o); i++) r[off_of(a, dw) + i] = 1'b1;
      return r;
   endfunction

   function automatic logic [63:0] m_wdata(input logic [5:0] o, input logic [63:0] sd, input int dw);
      logic [63:0] r = 64'd0;
      for (int i = 0; i < dw / 8; i++) r[8*i +: 8] = sd[8*(i % sz_of(o)) +: 8];
      return r;
   endfunction

   function automatic logic [63:0] m_load(input logic [5:0] o, input logic [63:0] rd,
                                          input logic [31:0] a, input int dw);
      int nb = 8 * sz_of(o);
      logic [63:0] v = 64'd0;
      for (int i = 0; i < nb; i++) v[i] = rd[8*off_of(a, dw) + i];
      if (is_sgn(o) && nb < dw && v[nb-1])
         for (int i = nb; i < 64; i++) v[i] = 1'b1;
      if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      nrst = 1'b0; exec_stall = 1'b0; fetch_stall = 1'b0; ack = 1'b0; err = 1'b0;
      op = 6'h01; dst = 5'd3; res = 64'h1234; mdata = '0; rdata = '0;
      tick; tick;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({obs_req[d], obs_stall[d], obs_rnw[d], obs_ea[d], obs_eb[d], obs_addr[d], obs_be[d],
              obs_wdata[d], obs_dst[d], obs_v[d], obs_exc_addr[d]} !== '0) begin
            failures++;
            $display("FAIL reset_outputs[%0d] req=%0b stall=%0b dst=%0h v=%0h addr=%0h be=%0h",
                     d, obs_req[d], obs_stall[d], obs_dst[d], obs_v[d], obs_addr[d], obs_be[d]);
         end
      end
      nrst = 1'b1;
   endtask

   task automatic test_nonmem;
      logic [4:0]  pd;
      logic [63:0] pr;
      for (int it = 0; it < 10; it++) begin
         op = 6'($urandom_range(0, 31)); dst = 5'($urandom); res = {$urandom, $urandom};
         exec_stall = 1'b0; fetch_stall = 1'b0;
         pd = dst; pr = res;
         tick;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_dst[d] !== pd || obs_v[d] !== (pr & dmask(d)) || obs_req[d] !== 1'b0) begin
               failures++;
               $display("FAIL nonmem[%0d] got dst=%0h v=%0h req=%0b exp dst=%0h v=%0h req=0",
                        d, obs_dst[d], obs_v[d], obs_req[d], pd, pr & dmask(d));
            end
         end
         // Either stall must freeze the writeback registers
         if (it % 2 == 0) exec_stall = 1'b1; else fetch_stall = 1'b1;
         op = 6'($urandom_range(0, 31)); dst = 5'($urandom); res = {$urandom, $urandom};
         tick;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_dst[d] !== pd || obs_v[d] !== (pr & dmask(d))) begin
               failures++;
               $display("FAIL stall_hold[%0d] got dst=%0h v=%0h exp dst=%0h v=%0h",
                        d, obs_dst[d], obs_v[d], pd, pr & dmask(d));
            end
         end
      end
      exec_stall = 1'b0; fetch_stall = 1'b0;
   endtask

   task automatic misalign_one(input logic [5:0] o, input logic [31:0] a);
      op = o; res = {$urandom, a}; dst = 5'($urandom_range(1, 31)); mdata = {$urandom, $urandom};
      exec_stall = 1'b0; fetch_stall = 1'b0;
      tick;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs_ea[d] !== 1'b1 || obs_exc_addr[d] !== a || obs_req[d] !== 1'b0 ||
             obs_stall[d] !== 1'b0 || obs_dst[d] !== 5'd0 || obs_eb[d] !== 1'b0) begin
            failures++;
            $display("FAIL misalign[%0d] op=%0h a=%0h got ea=%0b eaddr=%0h req=%0b stall=%0b dst=%0h exp ea=1 eaddr=%0h req=0 stall=0 dst=0",
                     d, o, a, obs_ea[d], obs_exc_addr[d], obs_req[d], obs_stall[d], obs_dst[d], a);
         end
      end
      exec_stall = 1'b1;
      tick;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs_ea[d] !== 1'b0 || obs_exc_addr[d] !== 32'd0 || obs_req[d] !== 1'b0) begin
            failures++;
            $display("FAIL misalign_pulse_end[%0d] got ea=%0b eaddr=%0h req=%0b exp 0 0 0",
                     d, obs_ea[d], obs_exc_addr[d], obs_req[d]);
         end
      end
      exec_stall = 1'b0;
   endtask

   task automatic test_misalign;
      logic [5:0] mops[5] = '{OP_LH, OP_LHU, OP_SH, OP_LW, OP_SW};
      logic [5:0] o;
      logic [31:0] a;
      misalign_one(OP_LW, 32'h0000_3001);
      for (int it = 0; it < 8; it++) begin
         o = mops[$urandom_range(0, 4)];
         a = $urandom;
         if (sz_of(o) == 2) a[0] = 1'b1;
         else a[1:0] = 2'($urandom_range(1, 3));
         misalign_one(o, a);
      end
   endtask

   // One memory op: accept, hold for `delay` busy cycles, then ack (with err if e).
   task automatic do_mem(input logic [5:0] o, input logic [31:0] a, input logic [63:0] sd,
                         input logic [63:0] rd, input int delay, input bit e);
      logic [4:0] dreg;
      int  n[2];
      bit  tout[2];
      dreg = 5'($urandom_range(1, 31));
      op = o; res = {$urandom, a}; mdata = sd; dst = dreg;
      exec_stall = 1'b0; fetch_stall = 1'b0; ack = 1'b0; err = 1'b0;
      for (int d = 0; d < 2; d++) begin
         tout[d] = (delay >= to_of(d));
         n[d]    = tout[d] ? to_of(d) : delay + 1;
      end
      tick;
      // Stalls and a changing op during BUSY must not disturb the transaction
      exec_stall = 1'b1; op = 6'($urandom_range(0, 31)); res = {$urandom, $urandom};
      for (int k = 0; k <= delay + 2; k++) begin
         for (int d = 0; d < 2; d++) begin
            if (k < n[d]) begin
               checks++;
               if (obs_req[d] !== 1'b1 || obs_stall[d] !== 1'b1 || obs_addr[d] !== m_addr(a, dw_of(d)) ||
                   obs_be[d] !== 8'(m_be(o, a, dw_of(d))) || obs_rnw[d] !== is_ld(o) ||
                   (!is_ld(o) && obs_wdata[d] !== m_wdata(o, sd, dw_of(d))) ||
                   obs_dst[d] !== 5'd0 || obs_eb[d] !== 1'b0 || obs_ea[d] !== 1'b0) begin
                  failures++;
                  $display("FAIL busy[%0d] op=%0h a=%0h k=%0d got req=%0b stall=%0b addr=%0h be=%0h rnw=%0b wd=%0h dst=%0h exp req=1 stall=1 addr=%0h be=%0h rnw=%0b wd=%0h dst=0",
                           d, o, a, k, obs_req[d], obs_stall[d], obs_addr[d], obs_be[d], obs_rnw[d],
                           obs_wdata[d], obs_dst[d], m_addr(a, dw_of(d)), 8'(m_be(o, a, dw_of(d))),
                           is_ld(o), m_wdata(o, sd, dw_of(d)));
               end
            end else if (k == n[d]) begin
               checks++;
               if (e || tout[d]) begin
                  if (obs_req[d] !== 1'b0 || obs_stall[d] !== 1'b0 || obs_eb[d] !== 1'b1 ||
                      obs_exc_addr[d] !== a || obs_dst[d] !== 5'd0) begin
                     failures++;
                     $display("FAIL bus_exc[%0d] op=%0h a=%0h got req=%0b stall=%0b eb=%0b eaddr=%0h dst=%0h exp req=0 stall=0 eb=1 eaddr=%0h dst=0",
                              d, o, a, obs_req[d], obs_stall[d], obs_eb[d], obs_exc_addr[d], obs_dst[d], a);
                  end
               end else begin
                  if (obs_req[d] !== 1'b0 || obs_stall[d] !== 1'b0 || obs_eb[d] !== 1'b0 ||
                      obs_exc_addr[d] !== 32'd0 || obs_dst[d] !== (is_ld(o) ? dreg : 5'd0) ||
                      (is_ld(o) && obs_v[d] !== m_load(o, rd, a, dw_of(d)))) begin
                     failures++;
                     $display("FAIL complete[%0d] op=%0h a=%0h got req=%0b stall=%0b eb=%0b dst=%0h v=%0h exp req=0 stall=0 eb=0 dst=%0h v=%0h",
                              d, o, a, obs_req[d], obs_stall[d], obs_eb[d], obs_dst[d], obs_v[d],
                              is_ld(o) ? dreg : 5'd0, m_load(o, rd, a, dw_of(d)));
                  end
               end
            end else begin
               checks++;
               if (obs_req[d] !== 1'b0 || obs_eb[d] !== 1'b0 || obs_stall[d] !== 1'b0) begin
                  failures++;
                  $display("FAIL after_done[%0d] k=%0d got req=%0b eb=%0b stall=%0b exp 0 0 0",
                           d, k, obs_req[d], obs_eb[d], obs_stall[d]);
               end
            end
         end
         ack   = (k == delay);
         err   = (k == delay) && e;
         rdata = (k == delay) ? rd : {$urandom, $urandom};
         tick;
      end
      ack = 1'b0; err = 1'b0;
   endtask

   task automatic test_plan_directed;
      do_mem(OP_LB, 32'h0000_1003, 64'd0, 64'h0000_0000_80AA_BBCC, 0, 1'b0);
      checks++;
      if (a_v !== 32'hFFFF_FF80 || a_be !== 4'b1000 || a_addr !== 32'h1000) begin
         failures++;
         $display("FAIL lb_1003 got v=%0h be=%0b addr=%0h exp v=ffffff80 be=1000 addr=1000", a_v, a_be, a_addr);
      end
      do_mem(OP_LBU, 32'h0000_1003, 64'd0, 64'h0000_0000_80AA_BBCC, 0, 1'b0);
      checks++;
      if (a_v !== 32'h0000_0080) begin
         failures++;
         $display("FAIL lbu_1003 got v=%0h exp v=80", a_v);
      end
      do_mem(OP_SH, 32'h0000_2002, 64'h0000_0000_1234_ABCD, 64'd0, 0, 1'b0);
      checks++;
      if (a_wdata !== 32'hABCD_ABCD || a_be !== 4'b1100 || a_rnw !== 1'b0 || a_dst !== 5'd0) begin
         failures++;
         $display("FAIL sh_2002 got wd=%0h be=%0b rnw=%0b dst=%0h exp wd=abcdabcd be=1100 rnw=0 dst=0",
                  a_wdata, a_be, a_rnw, a_dst);
      end
      do_mem(OP_LH, 32'h0000_4000, 64'd0, 64'h0000_0000_0000_F00D, 5, 1'b0);
      checks++;
      if (a_v !== 32'hFFFF_F00D) begin
         failures++;
         $display("FAIL lh_4000 got v=%0h exp v=fffff00d", a_v);
      end
      do_mem(OP_LW, 32'h0000_0104, 64'd0, 64'h8000_0001_0000_0000, 1, 1'b0);
      checks++;
      if (b_v !== 64'hFFFF_FFFF_8000_0001 || b_be !== 8'hF0) begin
         failures++;
         $display("FAIL lw64_104 got v=%0h be=%0h exp v=ffffffff80000001 be=f0", b_v, b_be);
      end
   endtask

   task automatic test_timeout;
      do_mem(OP_SW, 32'h0000_5000, {$urandom, $urandom}, 64'd0, 20, 1'b0);
      do_mem(OP_SW, 32'h0000_5000, {$urandom, $urandom}, 64'd0, 1, 1'b1);
      do_mem(OP_LW, 32'h0000_5008, 64'd0, {$urandom, $urandom}, 3, 1'b0);
   endtask

   task automatic test_random_mem;
      logic [5:0]  ops[8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
      logic [5:0]  o;
      logic [31:0] a;
      for (int it = 0; it < 40; it++) begin
         o = ops[$urandom_range(0, 7)];
         a = $urandom;
         a = a & ~32'(sz_of(o) - 1);
         do_mem(o, a, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 5), ($urandom_range(0, 7) == 0));
      end
   endtask

   task automatic test_back_to_back;
      logic [4:0]  d1, d2;
      logic [63:0] rd, r2;
      d1 = 5'd9; d2 = 5'd17; rd = {$urandom, $urandom}; r2 = {$urandom, $urandom};
      op = OP_LH; res = {32'd0, 32'h0000_4006}; dst = d1; exec_stall = 1'b0; fetch_stall = 1'b0;
      tick;
      op = 6'h05; res = r2; dst = d2;
      tick;
      ack = 1'b1; rdata = rd;
      tick;
      ack = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs_req[d] !== 1'b0 || obs_dst[d] !== d1 || obs_v[d] !== m_load(OP_LH, rd, 32'h4006, dw_of(d))) begin
            failures++;
            $display("FAIL b2b_load[%0d] got req=%0b dst=%0h v=%0h exp req=0 dst=%0h v=%0h",
                     d, obs_req[d], obs_dst[d], obs_v[d], d1, m_load(OP_LH, rd, 32'h4006, dw_of(d)));
         end
      end
      tick;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs_dst[d] !== d2 || obs_v[d] !== (r2 & dmask(d))) begin
            failures++;
            $display("FAIL b2b_next[%0d] got dst=%0h v=%0h exp dst=%0h v=%0h",
                     d, obs_dst[d], obs_v[d], d2, r2 & dmask(d));
         end
      end
      exec_stall = 1'b1;
   endtask

   task automatic test_reset_busy;
      op = 6'h02; res = 64'hDEAD_BEEF_CAFE_F00D; dst = 5'd7; exec_stall = 1'b0; fetch_stall = 1'b0;
      tick;
      op = OP_LW; res = {32'd0, 32'h0000_6000};
      tick;
      exec_stall = 1'b1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs_req[d] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_req[%0d] got req=%0b exp req=1", d, obs_req[d]);
         end
      end
      nrst = 1'b0;
      tick;
      nrst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({obs_req[d], obs_stall[d], obs_rnw[d], obs_ea[d], obs_eb[d], obs_addr[d], obs_be[d],
              obs_wdata[d], obs_dst[d], obs_v[d], obs_exc_addr[d]} !== '0) begin
            failures++;
            $display("FAIL reset_busy[%0d] got req=%0b stall=%0b dst=%0h v=%0h addr=%0h exp all 0",
                     d, obs_req[d], obs_stall[d], obs_dst[d], obs_v[d], obs_addr[d]);
         end
      end
      tick;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (obs_req[d] !== 1'b0 || obs_stall[d] !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle[%0d] got req=%0b stall=%0b exp 0 0", d, obs_req[d], obs_stall[d]);
         end
      end
      do_mem(OP_LHU, 32'h0000_7002, 64'd0, {$urandom, $urandom}, 2, 1'b0);
   endtask

   initial begin
      test_reset;
      test_nonmem;
      test_misalign;
      test_plan_directed;
      test_timeout;
      test_random_mem;
      test_back_to_back;
      test_reset_busy;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before the scenario list completed");
      $fatal(1);
   end

endmodule

// File: doc/memory_access_bus.md
Name: memory_access_bus

Overview:
- Parametrised successor of the memory access pipeline stage; sits between execute and writeback.
- Adds a req/ack bus handshake with a state machine, byte-lane alignment and enables, and local misalignment detection.
- Adds bus-error and timeout exception reporting, plus a registered writeback value.
- Supports 32- or 64-bit data paths.

Parameters:
DATA_WIDTH, 32, data/register width; legal values 32 or 64
ADDR_WIDTH, 32, address width
REGNO_WIDTH, 5, GPR index width
TIMEOUT, 255, maximum BUSY cycles without ack before a bus exception; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
nrst  in  1  reset; synchronous, active-low
i_exec_stall  in  1  execute stage stall
i_fetch_stall  in  1  fetch stage stall
o_mem_stall  out  1  this stage is busy (combinational, state==BUSY)
i_op  in  6  opcode (`CPU_OP_* from cpu_const.vh)
i_dst_gpr  in  REGNO_WIDTH  destination register
i_result  in  DATA_WIDTH  ALU result or effective address (low ADDR_WIDTH bits used)
i_mem_data  in  DATA_WIDTH  store data
o_req  out  1  bus request
o_addr  out  ADDR_WIDTH  bus address, lane-aligned (low OFFW bits zero)
o_rnw  out  1  1=read, 0=write
o_be  out  DATA_WIDTH/8  byte enables
o_wdata  out  DATA_WIDTH  lane-replicated store data
i_ack  in  1  bus completion, sampled only while o_req=1
i_rdata  in  DATA_WIDTH  read data, valid with i_ack
i_err  in  1  bus error, valid with i_ack
o_dst_gpr  out  REGNO_WIDTH  writeback register (0 = no write)
o_dst_gpr_v  out  DATA_WIDTH  writeback value (registered)
o_exc_align  out  1  misalignment pulse
o_exc_bus  out  1  bus error/timeout pulse
o_exc_addr  out  ADDR_WIDTH  full faulting address

Behaviour:
- OFFW = log2(DATA_WIDTH/8). Lanes are little-endian: lane k = bits [8k+7:8k]. off = effective address [OFFW-1:0].
- Reset (nrst low at a clk edge): every output is 0, state=IDLE, timeout counter=0. Reset wins over all other events, including mid-BUSY; o_req is 0 from the next cycle.
- States:
  - IDLE: accept when !i_exec_stall && !i_fetch_stall; otherwise all registered outputs hold.
  - BUSY: o_req=1; o_addr/o_be/o_wdata/o_rnw held stable.
- Non-memory op accepted: o_dst_gpr<=i_dst_gpr, o_dst_gpr_v<=i_result next cycle (1-cycle latency); stay IDLE.
- Memory op accepted, alignment check:
  - halfword misaligned if off[0]!=0; word misaligned if off[1:0]!=0.
  - Misaligned: no request; next cycle o_exc_align=1 for exactly one cycle, o_exc_addr<=i_result, o_dst_gpr<=0; stay IDLE.
- Memory op accepted and aligned, next cycle:
  - o_req=1, o_addr=addr with low OFFW bits cleared, o_rnw=load; o_dst_gpr<=0; state<=BUSY.
  - The load destination and op are latched internally.
  - o_be: byte = 1<<off; half = 3<<off; word = 4'hF<<off.
  - o_wdata: byte replicated to all lanes; half replicated; word replicated (64-bit).
- BUSY with i_ack=1 && i_err=0: next cycle o_req=0, state=IDLE.
  - Load: o_dst_gpr<=latched dst; o_dst_gpr_v<=lane extracted from i_rdata at off.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW sign-extends when DATA_WIDTH=64.
  - Store: o_dst_gpr stays 0.
- BUSY with i_ack=1 && i_err=1: next cycle o_req=0, o_exc_bus 1-cycle pulse, o_exc_addr=full original address, o_dst_gpr=0, state=IDLE.
- Timeout: counter increments on every BUSY cycle with no ack and clears on entering BUSY. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ack: same response as i_err. An ack in that same cycle wins (normal completion).
- o_mem_stall is 1 for the entire BUSY state, including the ack cycle. The next op can be accepted in the cycle after the ack (minimum 2 cycles per memory op).
- o_exc_* are 0 except during their pulse. Flushing after an exception is the CU's job; the stage accepts normally afterwards.
- i_ack while o_req=0 is ignored.
- Exec/fetch stalls during BUSY do not affect the bus transaction.

Test Plan (DATA_WIDTH=32 unless noted):
1. LB then LBU at 0x1003, i_rdata=0x80AABBCC, ack 1 cycle after req -> o_addr=0x1000, o_be=4'b1000, o_rnw=1; o_dst_gpr_v=0xFFFFFF80 then 0x00000080; o_dst_gpr=i_dst_gpr.
2. SH at 0x2002, i_mem_data=0x1234ABCD -> o_be=4'b1100, o_wdata=0xABCDABCD, o_rnw=0; after ack o_dst_gpr=0.
3. LW at 0x3001 -> no o_req; o_exc_align 1-cycle pulse, o_exc_addr=0x3001, o_mem_stall stays 0.
4. LH at 0x4000 with ack delayed 5 cycles -> o_req and o_mem_stall high 6 cycles, o_addr stable 0x4000; i_rdata=0x0000F00D gives o_dst_gpr_v=0xFFFFF00D; stalled i_op held and accepted the cycle after ack.
5. TIMEOUT=4, SW at 0x5000, never ack -> o_req drops after 4 cycles, o_exc_bus pulse, o_exc_addr=0x5000. Repeat with ack+i_err on cycle 2 -> same response, earlier.
6. nrst low for one edge while BUSY -> next cycle o_req=0, o_mem_stall=0, all outputs 0. DATA_WIDTH=64: LW at 0x...4, i_rdata=0x80000001_00000000 -> o_be=8'hF0, o_dst_gpr_v=0xFFFFFFFF80000001.
